// File: rtl/mem_pkg.sv
// mem_pkg: load-size encodings shared with the downstream load extractor,
// plus the read-controller state type.
package mem_pkg;

  // Load size encodings (same coding as the load extractor)
  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_BYTE = 2'b01;
  localparam logic [1:0] LS_HALF = 2'b10;
  localparam logic [1:0] LS_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_align_chk.sv
// mem_align_chk: combinational alignment check and lane shift for a load.
// Byte loads are never misaligned; the reserved size is always rejected.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] i_addr_lo,
  input  logic [1:0] i_ls_size,
  output logic       o_misaligned,
  output logic [4:0] o_shift_amt
);

  // Reject loads whose address does not match their size
  always_comb begin
    o_misaligned = 1'b0;
    case (i_ls_size)
      LS_WORD: o_misaligned = |i_addr_lo;
      LS_HALF: o_misaligned = i_addr_lo[0];
      LS_BYTE: o_misaligned = 1'b0;
      default: o_misaligned = 1'b1;
    endcase
  end

  // Right-shift in bits that brings the addressed byte lane down to bit 0
  assign o_shift_amt = {i_addr_lo, 3'b000};

endmodule

// File: rtl/mem_read_ctrl.sv
// mem_read_ctrl: issues one word-aligned memory read per accepted start,
// lane-aligns the returned data into mdr_out and pulses done, or pulses
// misalign_err for a bad address/size.
// Optional feature: define MEM_READ_TIMEOUT_EN to add an 8-bit REQ wait
// counter that abandons the read after TIMEOUT_CYCLES cycles without
// mem_ready. Without it REQ waits indefinitely and timeout_err is tied 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; only state that accepts a new load
//   REQ    | mem_req high, waiting for mem_ready (or timeout)
//   DONE   | one cycle, done=1, mdr_out holds the new load data
//   ERR    | one cycle, misalign_err=1, no memory access made
module mem_read_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [1:0]  ls_size,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mdr_out,
  output logic        busy,
  output logic        done,
  output logic        misalign_err,
  output logic        timeout_err
);

  // Catch an out-of-range timeout at elaboration
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_read_ctrl: TIMEOUT_CYCLES must be in 2..255");
  end

  state_e      r_state;
  state_e      w_next;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_mdr;
  logic [1:0]  w_chk_addr;
  logic [1:0]  w_chk_size;
  logic        w_misaligned;
  logic [4:0]  w_shift;
  logic        w_expire;

  // Checker sees the live request in IDLE and the latched one afterwards,
  // so one instance serves both the accept decision and the REQ lane shift
  always_comb begin
    w_chk_addr = r_addr[1:0];
    w_chk_size = r_size;
    if (r_state == S_IDLE) begin
      w_chk_addr = addr[1:0];
      w_chk_size = ls_size;
    end
  end

  mem_align_chk u_align_chk (
    .i_addr_lo    (w_chk_addr),
    .i_ls_size    (w_chk_size),
    .o_misaligned (w_misaligned),
    .o_shift_amt  (w_shift)
  );

`ifdef MEM_READ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wait_cnt;
  logic       r_timeout_err;

  // Count REQ cycles without mem_ready; zero whenever not in REQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state != S_REQ) begin
      r_wait_cnt <= 8'd0;
    end else if (!mem_ready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

  assign w_expire = (r_wait_cnt == TO_LAST);

  // Timeout pulse lands in the IDLE cycle after the abandoned REQ
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= (r_state == S_REQ) && !mem_ready && w_expire;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_expire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; mem_ready wins over an expiring count
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_misaligned ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          w_next = S_DONE;
        end else if (w_expire) begin
          w_next = S_IDLE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the request when it is accepted in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= 32'd0;
      r_size <= LS_WORD;
    end else if (r_state == S_IDLE && start) begin
      r_addr <= addr;
      r_size <= ls_size;
    end
  end

  // Capture lane-aligned read data; held across errors and timeouts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mdr <= 32'd0;
    end else if (r_state == S_REQ && mem_ready) begin
      r_mdr <= mem_rdata >> w_shift;
    end
  end

  assign mem_req      = (r_state == S_REQ);
  assign mem_addr     = (r_state == S_REQ) ? {r_addr[31:2], 2'b00} : 32'd0;
  assign mdr_out      = r_mdr;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign misalign_err = (r_state == S_ERR);

endmodule

// File: doc/mem_read_ctrl.md
MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, maximum REQ-state cycles waiting for mem_ready; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to perform one load.
REQ-005 addr  input  32  byte address of the load.
REQ-006 ls_size  input  2  size: 00 word, 10 halfword, 01 byte, 11 reserved; same encoding as the downstream load extractor.
REQ-007 mem_req  output  1  memory read request, held until mem_ready.
REQ-008 mem_addr  output  32  word-aligned address presented to memory.
REQ-009 mem_ready  input  1  memory data valid this cycle.
REQ-010 mem_rdata  input  32  memory read data.
REQ-011 mdr_out  output  32  registered, lane-aligned load data feeding the load extractor.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse: mdr_out newly valid.
REQ-014 misalign_err  output  1  one-cycle pulse: load rejected for alignment or reserved size.
REQ-015 timeout_err  output  1  one-cycle pulse: memory did not answer in time.

Function
REQ-016 FSM states SHALL be IDLE, REQ, DONE, ERR.
REQ-017 In IDLE, start=1 SHALL latch addr and ls_size and go to ERR if misaligned, else to REQ.
REQ-018 Misaligned: word with addr[1:0]!=0; halfword with addr[0]!=0; any ls_size=11; byte is never misaligned.
REQ-019 ERR SHALL last one cycle with misalign_err=1, then go to IDLE; mdr_out unchanged, no mem_req issued.
REQ-020 In REQ, mem_req=1 and mem_addr={latched addr[31:2],2'b00}; mem_addr is 0 outside REQ.
REQ-021 In REQ with mem_ready=1, mdr_out SHALL capture mem_rdata >> (8*latched addr[1:0]) with zero fill, and the FSM goes to DONE.
REQ-022 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-023 Latency: start at cycle 0 gives mem_req at cycle 1; mem_ready sampled at cycle N gives mdr_out valid and done=1 at cycle N+1.
REQ-024 start while busy=1 SHALL be ignored; mem_ready outside REQ SHALL be ignored.
REQ-025 mdr_out SHALL hold its value between captures, including across errors.
REQ-026 start in the DONE or ERR cycle is ignored; the next load needs start in IDLE.

Reset
REQ-027 Asserting reset_n low SHALL immediately force IDLE, mdr_out=0, mem_req=0, mem_addr=0, busy=0, done=0, misalign_err=0, timeout_err=0, and wait counter=0.
REQ-028 Reset during REQ SHALL abandon the request with no done pulse; a mem_ready arriving after reset is ignored.

Configuration
REQ-029 With MEM_READ_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without mem_ready; on reaching TIMEOUT_CYCLES, timeout_err pulses one cycle, mem_req drops, the FSM returns to IDLE, and mdr_out is unchanged.
REQ-030 mem_ready in the same cycle the count would expire SHALL take priority: normal capture, no timeout_err.
REQ-031 Without MEM_READ_TIMEOUT_EN, REQ SHALL wait indefinitely, timeout_err SHALL be constant 0, and no counter SHALL be synthesized.

Structure
REQ-032 A shared package mem_pkg SHALL hold the ls_size encodings (LS_WORD, LS_HALF, LS_BYTE, LS_RSVD) and the FSM state typedef; the downstream load extractor uses the same size constants.
REQ-033 The alignment check and lane shift SHALL be a combinational sub-module mem_align_chk with inputs addr[1:0] and ls_size and outputs misaligned and shift amount.

Verification
REQ-034 Word load: addr=0x100, ls_size=00, mem_ready after 3 REQ cycles, rdata=0xDEADBEEF -> mem_addr=0x100, done one cycle later, mdr_out=0xDEADBEEF.
REQ-035 Byte load: addr=0x103, ls_size=01, rdata=0xAABBCCDD -> mem_addr=0x100, mdr_out=0x000000AA.
REQ-036 Misaligned half: addr=0x101, ls_size=10 -> misalign_err pulse, mem_req never asserted, mdr_out unchanged.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): mem_ready held 0 -> timeout_err pulses after 16 REQ cycles, then IDLE; a second test raises mem_ready on cycle 16 and expects a normal capture with no timeout_err.
REQ-038 Reset mid-REQ: reset_n low at REQ cycle 2, mem_ready high after release -> all outputs 0, no done pulse.
REQ-039 Back-to-back: start held high through the transaction -> exactly one load per IDLE entry, with no start accepted during REQ, DONE or ERR.
